// File: rtl/ppm_sram_writer_pkg.sv
// Shared types and constants for the PPM-to-SRAM loader.
package ppm_writer_pkg;

    typedef enum logic [2:0] {
        S_PW_IDLE,
        S_PW_HEADER,
        S_PW_PAYLOAD,
        S_PW_DONE,
        S_PW_ERROR
    } pw_state_type;

    localparam logic [7:0]  PPM_LF            = 8'h0A;
    localparam int unsigned PW_ADDR_W         = 18;
    localparam int unsigned PW_DATA_W         = 16;
    // 320 x 240 pixels, 3 bytes each, two bytes per SRAM word.
    localparam int unsigned PPM_DEFAULT_WORDS = 320 * 240 * 3 / 2;

endpackage

// File: rtl/ppm_sram_writer_if.sv
// UART byte input, start control, SRAM write port and status of the PPM loader.
interface ppm_sram_writer_if;
    import ppm_writer_pkg::*;

    logic                 Start;
    logic [7:0]           Rx_data;
    logic                 Rx_valid;
    logic [PW_ADDR_W-1:0] SRAM_address;
    logic [PW_DATA_W-1:0] SRAM_write_data;
    logic                 SRAM_we_n;
    logic [PW_ADDR_W-1:0] Word_count;
    logic                 Busy;
    logic                 Done;
    logic                 Header_error;

    modport slave (
        input  Start, Rx_data, Rx_valid,
        output SRAM_address, SRAM_write_data, SRAM_we_n,
        output Word_count, Busy, Done, Header_error
    );

    modport master (
        output Start, Rx_data, Rx_valid,
        input  SRAM_address, SRAM_write_data, SRAM_we_n,
        input  Word_count, Busy, Done, Header_error
    );
endinterface

// File: rtl/ppm_sram_writer_header_filter.sv
// Counts header bytes and line feeds; pulses header_done on the terminating LF
// and header_error when the header grows past its length limit.
module ppm_header_filter
    import ppm_writer_pkg::*;
#(
    parameter int unsigned NUM_HEADER_LINES = 3,
    parameter int unsigned MAX_HEADER_BYTES = 64
) (
    input  logic       clk,
    input  logic       srst,
    input  logic       clear,
    input  logic       enable,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic       header_done,
    output logic       header_error
);

    localparam int LF_W   = $clog2(NUM_HEADER_LINES + 1);
    localparam int BYTE_W = $clog2(MAX_HEADER_BYTES + 1);

    logic [LF_W-1:0]   lf_count_reg;
    logic [BYTE_W-1:0] byte_count_reg;
    logic              take;
    logic              is_lf;

    assign take  = enable && rx_valid;
    assign is_lf = (rx_data == PPM_LF);

    // The terminating LF wins over the length limit when both land on one byte.
    assign header_done  = take && is_lf && (lf_count_reg == LF_W'(NUM_HEADER_LINES - 1));
    assign header_error = take && !header_done &&
                          (byte_count_reg == BYTE_W'(MAX_HEADER_BYTES));

    always_ff @(posedge clk) begin
        if (srst || clear) begin
            lf_count_reg   <= '0;
            byte_count_reg <= '0;
        end else if (take) begin
            byte_count_reg <= byte_count_reg + BYTE_W'(1);
            if (is_lf) begin
                lf_count_reg <= lf_count_reg + LF_W'(1);
            end
        end
    end

endmodule

// File: rtl/ppm_sram_writer.sv
// Strips the PPM text header from the UART byte stream and writes the payload
// as big-endian 16-bit words to consecutive SRAM addresses.
module ppm_sram_writer
    import ppm_writer_pkg::*;
#(
    parameter int unsigned          NUM_HEADER_LINES = 3,
    parameter int unsigned          NUM_WORDS        = PPM_DEFAULT_WORDS,
    parameter logic [PW_ADDR_W-1:0] BASE_ADDR        = 18'd0,
    parameter int unsigned          MAX_HEADER_BYTES = 64
) (
    input  logic             Clock_50,
    input  logic             Reset,
    ppm_sram_writer_if.slave bus
);

    localparam logic [PW_ADDR_W-1:0] LAST_WORD_IDX = PW_ADDR_W'(NUM_WORDS - 1);

    pw_state_type         state_reg, state_next;
    logic [PW_ADDR_W-1:0] address_reg;
    logic [PW_ADDR_W-1:0] word_count_reg;
    logic [PW_DATA_W-1:0] write_data_reg;
    logic [7:0]           hi_byte_reg;
    logic                 hi_flag_reg;
    logic                 we_n_reg;

    logic clear_all;
    logic load_hi;
    logic load_lo;
    logic write_retire;
    logic final_retire;
    logic header_active;
    logic header_done;
    logic header_error;

    // A write retires at the end of its we_n-low cycle.
    assign write_retire  = !we_n_reg;
    assign final_retire  = write_retire && (word_count_reg == LAST_WORD_IDX);
    assign header_active = (state_reg == S_PW_HEADER);

    ppm_header_filter #(
        .NUM_HEADER_LINES (NUM_HEADER_LINES),
        .MAX_HEADER_BYTES (MAX_HEADER_BYTES)
    ) u_header_filter (
        .clk          (Clock_50),
        .srst         (Reset),
        .clear        (clear_all),
        .enable       (header_active),
        .rx_valid     (bus.Rx_valid),
        .rx_data      (bus.Rx_data),
        .header_done  (header_done),
        .header_error (header_error)
    );

    always_ff @(posedge Clock_50) begin
        if (Reset) begin
            state_reg <= S_PW_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        clear_all  = 1'b0;
        load_hi    = 1'b0;
        load_lo    = 1'b0;
        case (state_reg)
            S_PW_IDLE, S_PW_DONE, S_PW_ERROR: begin
                if (bus.Start) begin
                    state_next = S_PW_HEADER;
                    clear_all  = 1'b1;
                end
            end
            S_PW_HEADER: begin
                if (header_done) begin
                    state_next = S_PW_PAYLOAD;
                end else if (header_error) begin
                    state_next = S_PW_ERROR;
                end
            end
            S_PW_PAYLOAD: begin
                // Bytes arriving while the last word is being written are surplus.
                if (final_retire) begin
                    state_next = S_PW_DONE;
                end else if (bus.Rx_valid) begin
                    load_hi = !hi_flag_reg;
                    load_lo = hi_flag_reg;
                end
            end
            default: state_next = S_PW_IDLE;
        endcase
    end

    always_ff @(posedge Clock_50) begin
        if (Reset) begin
            address_reg    <= BASE_ADDR;
            word_count_reg <= '0;
            write_data_reg <= '0;
            hi_byte_reg    <= '0;
            hi_flag_reg    <= 1'b0;
            we_n_reg       <= 1'b1;
        end else begin
            we_n_reg <= !load_lo;
            if (clear_all) begin
                address_reg    <= BASE_ADDR;
                word_count_reg <= '0;
                hi_flag_reg    <= 1'b0;
            end else if (write_retire) begin
                address_reg    <= address_reg + PW_ADDR_W'(1);
                word_count_reg <= word_count_reg + PW_ADDR_W'(1);
            end
            // The hi byte waits in its own register so the word on the bus
            // only changes when a complete word is ready.
            if (load_hi) begin
                hi_byte_reg <= bus.Rx_data;
                hi_flag_reg <= 1'b1;
            end
            if (load_lo) begin
                write_data_reg <= {hi_byte_reg, bus.Rx_data};
                hi_flag_reg    <= 1'b0;
            end
        end
    end

    assign bus.SRAM_address    = address_reg;
    assign bus.SRAM_write_data = write_data_reg;
    assign bus.SRAM_we_n       = we_n_reg;
    assign bus.Word_count      = word_count_reg;
    assign bus.Busy            = (state_reg == S_PW_HEADER) || (state_reg == S_PW_PAYLOAD);
    assign bus.Done            = (state_reg == S_PW_DONE);
    assign bus.Header_error    = (state_reg == S_PW_ERROR);

endmodule

// File: tb/tb_ppm_sram_writer.sv
// Bench for ppm_sram_writer: directed vector table, cycle-level corner cases,
// and random streams checked against a stream-level model of the loader.
module tb_ppm_sram_writer;
    import ppm_writer_pkg::*;

    localparam int          NHL  = 3;
    localparam int          NW   = 4;
    localparam int          MAXH = 64;
    localparam logic [17:0] BASE = 18'h00010;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ppm_sram_writer_if bus();

    ppm_sram_writer #(
        .NUM_HEADER_LINES (NHL),
        .NUM_WORDS        (NW),
        .BASE_ADDR        (BASE),
        .MAX_HEADER_BYTES (MAXH)
    ) dut (
        .Clock_50 (clk),
        .Reset    (rst),
        .bus      (bus)
    );

    int          checks = 0;
    int          passed = 0;
    logic [33:0] wlog[$];
    logic        prev_we_n = 1'b1;
    logic [7:0]  stream_q[$];
    logic [15:0] exp_q[$];
    logic        exp_done;
    logic        exp_err;

    typedef struct {
        bit               hdr_kind;   // 0: "P6\n320 240\n255\n", 1: "\n\n\n"
        int               pl_n;
        logic [0:11][7:0] pl;
        int               gap;
        int               exp_n;
        logic [0:3][15:0] exp_w;
        logic             exp_done;
    } vec_t;

    vec_t vt[5];

    task automatic check(input string name, input logic [33:0] act, input logic [33:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (bus.SRAM_we_n === 1'b0) begin
            check("we_n_single_cycle", 34'(prev_we_n), 34'(1));
            wlog.push_back({bus.SRAM_address, bus.SRAM_write_data});
            $display("write addr=%05h data=%04h", bus.SRAM_address, bus.SRAM_write_data);
        end
        prev_we_n = bus.SRAM_we_n;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.Start = 1'b0;
        bus.Rx_valid = 1'b0;
        tick();
        rst = 1'b0;
        wlog.delete();
    endtask

    task automatic pulse_start();
        bus.Start = 1'b1;
        tick();
        bus.Start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bus.Rx_data = b;
        bus.Rx_valid = 1'b1;
        tick();
        bus.Rx_valid = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic send_header(input bit kind, input int gap);
        string h;
        h = kind ? "\n\n\n" : "P6\n320 240\n255\n";
        for (int i = 0; i < h.len(); i++) send_byte(h[i], gap);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " we_n"}, 34'(bus.SRAM_we_n), 34'(1));
        check({tag, " addr"}, 34'(bus.SRAM_address), 34'(BASE));
        check({tag, " data"}, 34'(bus.SRAM_write_data), 34'(0));
        check({tag, " word_count"}, 34'(bus.Word_count), 34'(0));
        check({tag, " flags"}, 34'({bus.Busy, bus.Done, bus.Header_error}), 34'(0));
    endtask

    // Stream-level reference: locate the end of the header, then pair bytes.
    task automatic run_model();
        int lf;
        int hdr_end;
        lf = 0;
        hdr_end = -1;
        exp_q.delete();
        exp_err = 1'b0;
        exp_done = 1'b0;
        for (int i = 0; i < stream_q.size(); i++) begin
            if (stream_q[i] == PPM_LF) lf++;
            if (lf == NHL) begin
                hdr_end = i;
                break;
            end
            if (i + 1 > MAXH) begin
                exp_err = 1'b1;
                break;
            end
        end
        if (hdr_end >= 0) begin
            for (int i = hdr_end + 1; i + 1 < stream_q.size() && exp_q.size() < NW; i += 2)
                exp_q.push_back({stream_q[i], stream_q[i+1]});
            exp_done = (exp_q.size() == NW);
        end
    endtask

    task automatic check_against(input string tag);
        check({tag, " nwrites"}, 34'(wlog.size()), 34'(exp_q.size()));
        for (int i = 0; i < wlog.size() && i < exp_q.size(); i++)
            check($sformatf("%s word%0d", tag, i), wlog[i], {BASE + 18'(i), exp_q[i]});
        check({tag, " word_count"}, 34'(bus.Word_count), 34'(exp_q.size()));
        check({tag, " done"}, 34'(bus.Done), 34'(exp_done));
        check({tag, " header_error"}, 34'(bus.Header_error), 34'(exp_err));
        check({tag, " busy"}, 34'(bus.Busy), 34'(!exp_done && !exp_err));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.Start = 1'b0;
        bus.Rx_valid = 1'b0;
        bus.Rx_data = 8'h00;

        vt[0] = '{1'b0, 10, {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'hAA, 8'h00, 8'h00},
                  0, 4, {16'h1122, 16'h3344, 16'h5566, 16'h7788}, 1'b1};
        vt[1] = '{1'b0, 2, {8'h0A, 8'h0B, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                  1, 1, {16'h0A0B, 16'h0000, 16'h0000, 16'h0000}, 1'b0};
        vt[2] = '{1'b1, 10, {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A, 8'h00, 8'h00},
                  2, 4, {16'h0102, 16'h0304, 16'h0506, 16'h0708}, 1'b1};
        vt[3] = '{1'b0, 1, {8'hAB, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                  0, 0, {16'h0000, 16'h0000, 16'h0000, 16'h0000}, 1'b0};
        vt[4] = '{1'b1, 6, {8'h0A, 8'h0A, 8'h0A, 8'h0A, 8'h0A, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                  0, 3, {16'h0A0A, 16'h0A0A, 16'h0A0A, 16'h0000}, 1'b0};

        do_reset();
        check_reset_outputs("reset");

        for (int r = 0; r < 5; r++) begin
            do_reset();
            pulse_start();
            send_header(vt[r].hdr_kind, vt[r].gap);
            for (int i = 0; i < vt[r].pl_n; i++) send_byte(vt[r].pl[i], vt[r].gap);
            repeat (4) tick();
            exp_q.delete();
            for (int i = 0; i < vt[r].exp_n; i++) exp_q.push_back(vt[r].exp_w[i]);
            exp_done = vt[r].exp_done;
            exp_err = 1'b0;
            check_against($sformatf("vec%0d", r));
            $display("vector %0d applied: %0d writes", r, wlog.size());
        end

        // Cycle-exact write timing with back-to-back bytes.
        do_reset();
        pulse_start();
        send_header(1'b1, 0);
        bus.Rx_valid = 1'b1;
        bus.Rx_data = 8'hC3;
        tick();
        bus.Rx_data = 8'h5A;
        tick();
        check("lat we_n low", 34'(bus.SRAM_we_n), 34'(0));
        check("lat word0", {bus.SRAM_address, bus.SRAM_write_data}, {BASE, 16'hC35A});
        bus.Rx_data = 8'h77;
        tick();
        check("lat we_n high", 34'(bus.SRAM_we_n), 34'(1));
        check("lat after write", {bus.SRAM_address, bus.SRAM_write_data}, {BASE + 18'd1, 16'hC35A});
        check("lat word_count1", 34'(bus.Word_count), 34'(1));
        bus.Rx_data = 8'h88;
        tick();
        check("lat word1", {bus.SRAM_we_n, bus.SRAM_address, bus.SRAM_write_data},
              {1'b0, BASE + 18'd1, 16'h7788});
        bus.Rx_valid = 1'b0;
        tick();
        check("lat word_count2", 34'(bus.Word_count), 34'(2));

        // Start while busy is ignored; the load continues where it was.
        pulse_start();
        check("busy start flags", 34'({bus.Busy, bus.Done, bus.Header_error}), 34'(3'b100));
        check("busy start word_count", 34'(bus.Word_count), 34'(2));
        send_byte(8'h01, 0);
        send_byte(8'h02, 0);
        tick();
        check("busy start word2", wlog[wlog.size()-1], {BASE + 18'd2, 16'h0102});
        check("busy start word_count3", 34'(bus.Word_count), 34'(3));

        // Reset with a half word pending, then a fresh load from BASE.
        send_byte(8'hEE, 0);
        do_reset();
        check_reset_outputs("midreset");
        pulse_start();
        send_header(1'b1, 0);
        send_byte(8'hDE, 0);
        send_byte(8'hAD, 0);
        tick();
        check("midreset nwrites", 34'(wlog.size()), 34'(1));
        if (wlog.size() > 0) check("midreset word0", wlog[0], {BASE, 16'hDEAD});

        // Header length limit: 64 bytes are fine, the 65th is an error.
        do_reset();
        pulse_start();
        repeat (MAXH) send_byte(8'h41, 0);
        check("hdr64 flags", 34'({bus.Busy, bus.Done, bus.Header_error}), 34'(3'b100));
        send_byte(8'h41, 0);
        check("hdr65 flags", 34'({bus.Busy, bus.Done, bus.Header_error}), 34'(3'b001));
        send_header(1'b1, 0);
        send_byte(8'h99, 0);
        send_byte(8'h98, 0);
        repeat (3) tick();
        check("hdr65 nwrites", 34'(wlog.size()), 34'(0));
        check("hdr65 sticky", 34'(bus.Header_error), 34'(1));
        pulse_start();
        check("restart flags", 34'({bus.Busy, bus.Done, bus.Header_error}), 34'(3'b100));
        send_header(1'b1, 0);
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        send_byte(8'h56, 0);
        send_byte(8'h78, 0);
        tick();
        check("restart nwrites", 34'(wlog.size()), 34'(2));
        if (wlog.size() == 2) begin
            check("restart word0", wlog[0], {BASE, 16'h1234});
            check("restart word1", wlog[1], {BASE + 18'd1, 16'h5678});
        end

        // Random streams against the model.
        for (int it = 0; it < 25; it++) begin
            int   hlen;
            int   plen;
            logic [7:0] b;
            stream_q.delete();
            hlen = int'($urandom_range(3, 68));
            for (int i = 0; i < hlen; i++) begin
                b = 8'($urandom_range(0, 255));
                if (b == PPM_LF) b = 8'h20;
                stream_q.push_back(b);
            end
            stream_q[hlen-1] = PPM_LF;
            stream_q[$urandom_range(0, hlen - 2)] = PPM_LF;
            stream_q[$urandom_range(0, hlen - 2)] = PPM_LF;
            plen = int'($urandom_range(0, 12));
            for (int i = 0; i < plen; i++) begin
                b = ($urandom_range(0, 3) == 0) ? PPM_LF : 8'($urandom_range(0, 255));
                stream_q.push_back(b);
            end
            do_reset();
            pulse_start();
            for (int i = 0; i < stream_q.size(); i++)
                send_byte(stream_q[i], int'($urandom_range(0, 2)));
            repeat (4) tick();
            run_model();
            check_against($sformatf("rand%0d", it));
            $display("random stream %0d: %0d bytes, %0d writes", it, stream_q.size(), wlog.size());
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
